// File: rtl/sdram_port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_port_arbiter_if : per-channel request/response bundle of masters   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface sdram_port_arbiter_if #(
  parameter int Channels        = 2,
  parameter int AddressBitWidth = 21
);
  logic [Channels-1:0]                 ch_req;
  logic [Channels-1:0]                 ch_write;
  logic [Channels*AddressBitWidth-1:0] ch_address;
  logic [Channels*32-1:0]              ch_data_in;
  logic [Channels*4-1:0]               ch_dqm;
  logic [Channels-1:0]                 ch_ack;
  logic [31:0]                         ch_data_out;

  modport master (
    output ch_req, ch_write, ch_address, ch_data_in, ch_dqm,
    input  ch_ack, ch_data_out
  );

  modport slave (
    input  ch_req, ch_write, ch_address, ch_data_in, ch_dqm,
    output ch_ack, ch_data_out
  );
endinterface
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sdram_port_arbiter : N-master arbiter in front of an SDRAM controller,   |
// | with periodic auto-refresh. Define SDRAM_ARB_FIXED_PRIORITY_EN for fixed |
// | priority (lowest index wins) instead of round-robin.                     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sdram_port_arbiter #(
  parameter int         Channels              = 2,
  parameter int         AddressBitWidth       = 21,
  parameter int         ReadLatency           = 4,
  parameter int         RefreshIntervalCycles = 800,
  parameter logic [2:0] CmdWrite              = 3'b100,
  parameter logic [2:0] CmdRead               = 3'b101,
  parameter logic [2:0] CmdRefresh            = 3'b001
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  sdram_port_arbiter_if.slave             chan,
  output logic                            I_sdrc_cmd_en,
  output logic [2:0]                      I_sdrc_cmd,
  output logic [AddressBitWidth-1:0]      I_sdrc_addr,
  output logic [3:0]                      I_sdrc_dqm,
  output logic [31:0]                     I_sdrc_data,
  output logic [7:0]                      I_sdrc_data_len,
  input  wire logic [31:0]                O_sdrc_data,
  input  wire logic                       O_sdrc_cmd_ack,
  input  wire logic                       O_sdrc_init_done,
  output logic                            busy
);

  localparam int IdxW = (Channels > 1) ? $clog2(Channels) : 1;
  localparam int CntW = (RefreshIntervalCycles > 2) ? $clog2(RefreshIntervalCycles) : 1;
  localparam int LatW = $clog2(ReadLatency + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RefreshIntervalCycles - 1);
  localparam logic [LatW-1:0] LatEnd = LatW'(ReadLatency);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DATA = 3'd3,
    REFRESH   = 3'd4
  } state_t;

  state_t              state;
  logic [CntW-1:0]     ref_cnt;
  logic                refresh_due;
  logic [IdxW-1:0]     gnt_idx;
  logic                gnt_write;
  logic [LatW-1:0]     lat_cnt;
  logic [Channels-1:0] ack_r;
  logic [31:0]         data_out_r;
  logic [IdxW-1:0]     sel_idx;
  logic                sel_valid;
  logic                grant_fire;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = Channels - 1; k >= 0; k--) begin
      if (chan.ch_req[k]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(k);
      end
    end
  end
`else
  logic [IdxW-1:0] rr_ptr;

  always_comb begin
    int cand;
    cand      = 0;
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < Channels; k++) begin
      cand = (int'(rr_ptr) + k) % Channels;
      if (!sel_valid && chan.ch_req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_fire) begin
      rr_ptr <= (int'(sel_idx) + 1 == Channels) ? '0 : sel_idx + 1'b1;
    end
  end
`endif

  // No grant while an ack is visible: the master has not yet dropped its request.
  assign grant_fire = (state == IDLE) && O_sdrc_init_done && !refresh_due
                      && !(|ack_r) && sel_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ref_cnt       <= '0;
      refresh_due   <= 1'b0;
      gnt_idx       <= '0;
      gnt_write     <= 1'b0;
      lat_cnt       <= '0;
      ack_r         <= '0;
      data_out_r    <= '0;
      I_sdrc_cmd_en <= 1'b0;
      I_sdrc_cmd    <= '0;
      I_sdrc_addr   <= '0;
      I_sdrc_dqm    <= '0;
      I_sdrc_data   <= '0;
    end else begin
      ack_r <= '0;

      if (state == IDLE && !O_sdrc_init_done) begin
        ref_cnt <= '0;
      end else if (ref_cnt != CntMax) begin
        ref_cnt <= ref_cnt + 1'b1;
        if (ref_cnt == CntMax - 1'b1) refresh_due <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (O_sdrc_init_done && refresh_due) begin
            state         <= REFRESH;
            I_sdrc_cmd_en <= 1'b1;
            I_sdrc_cmd    <= CmdRefresh;
            ref_cnt       <= '0;
            refresh_due   <= 1'b0;
          end else if (grant_fire) begin
            state         <= ISSUE;
            I_sdrc_cmd_en <= 1'b1;
            I_sdrc_cmd    <= chan.ch_write[sel_idx] ? CmdWrite : CmdRead;
            I_sdrc_addr   <= chan.ch_address[int'(sel_idx)*AddressBitWidth +: AddressBitWidth];
            I_sdrc_data   <= chan.ch_data_in[int'(sel_idx)*32 +: 32];
            I_sdrc_dqm    <= chan.ch_dqm[int'(sel_idx)*4 +: 4];
            gnt_idx       <= sel_idx;
            gnt_write     <= chan.ch_write[sel_idx];
          end
        end
        ISSUE: begin
          I_sdrc_cmd_en <= 1'b0;
          state         <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (O_sdrc_cmd_ack) begin
            if (gnt_write) begin
              ack_r[gnt_idx] <= 1'b1;
              state          <= IDLE;
            end else begin
              lat_cnt <= LatW'(1);
              state   <= WAIT_DATA;
            end
          end
        end
        WAIT_DATA: begin
          // lat_cnt equals the number of cycles elapsed since the ack cycle.
          if (lat_cnt == LatEnd) begin
            data_out_r     <= O_sdrc_data;
            ack_r[gnt_idx] <= 1'b1;
            state          <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        REFRESH: begin
          I_sdrc_cmd_en <= 1'b0;
          if (O_sdrc_cmd_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign chan.ch_ack      = ack_r;
  assign chan.ch_data_out = data_out_r;
  assign I_sdrc_data_len  = 8'd0;
  assign busy             = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sdram_port_arbiter : directed bench with a simple controller model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sdram_port_arbiter;
  localparam int CH = 2, AW = 21, RL = 4, RI = 16;
  localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_RF = 3'b001;
  // Read occupancy from ISSUE to the IDLE ack cycle: 1 + 2 + RL + 1.
  localparam int MAX_GAP = RI + 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.Channels(CH), .AddressBitWidth(AW)) bus ();

  logic          cmd_en, cmd_ack, init_done, busy;
  logic [2:0]    cmd;
  logic [AW-1:0] addr;
  logic [3:0]    dqm;
  logic [31:0]   wdata, rdata;
  logic [7:0]    dlen;

  sdram_port_arbiter #(
    .Channels(CH), .AddressBitWidth(AW), .ReadLatency(RL),
    .RefreshIntervalCycles(RI), .CmdWrite(C_WR), .CmdRead(C_RD), .CmdRefresh(C_RF)
  ) dut (
    .clk(clk), .rst(rst), .chan(bus),
    .I_sdrc_cmd_en(cmd_en), .I_sdrc_cmd(cmd), .I_sdrc_addr(addr),
    .I_sdrc_dqm(dqm), .I_sdrc_data(wdata), .I_sdrc_data_len(dlen),
    .O_sdrc_data(rdata), .O_sdrc_cmd_ack(cmd_ack), .O_sdrc_init_done(init_done),
    .busy(busy)
  );

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: ack two cycles after cmd_en, read data RL cycles after ack.
  logic [31:0]   mem [0:63];
  int            ack_cd, rd_cd, n_cmds, n_refresh, last_ref, min_gap, max_gap, violations;
  logic          outstanding, rd_acked;
  logic [2:0]    pend_cmd, last_cmd;
  logic [5:0]    pend_addr, rd_addr;
  logic [31:0]   pend_data, last_data;
  logic [3:0]    pend_dqm;
  logic [AW-1:0] last_addr;
  logic [7:0]    last_len;

  always @(negedge clk) begin
    if (rst) begin
      ack_cd = 0; rd_cd = 0; cmd_ack = 1'b0; outstanding = 1'b0;
      rdata = 32'h0BAD0BAD; last_ref = -1;
    end else begin
      rdata = 32'h0BAD0BAD;
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) rdata = mem[rd_addr];
      end
      cmd_ack = 1'b0;
      if (ack_cd > 0) begin
        ack_cd--;
        if (ack_cd == 0) begin
          cmd_ack = 1'b1;
          outstanding = 1'b0;
          if (pend_cmd == C_WR) begin
            for (int b = 0; b < 4; b++)
              if (!pend_dqm[b]) mem[pend_addr][8*b +: 8] = pend_data[8*b +: 8];
          end else if (pend_cmd == C_RD) begin
            rd_cd = RL; rd_addr = pend_addr; rd_acked = 1'b1;
          end
        end
      end
      if ($countones(bus.ch_ack) > 1) violations++;
      if (cmd_en) begin
        if (outstanding) violations++;
        outstanding = 1'b1; ack_cd = 2; n_cmds++;
        pend_cmd = cmd; pend_addr = addr[5:0]; pend_data = wdata; pend_dqm = dqm;
        last_cmd = cmd; last_addr = addr; last_data = wdata; last_len = dlen;
        if (cmd == C_RF) begin
          n_refresh++;
          if (last_ref >= 0) begin
            if (cyc - last_ref < min_gap) min_gap = cyc - last_ref;
            if (cyc - last_ref > max_gap) max_gap = cyc - last_ref;
          end
          last_ref = cyc;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic wr, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] m);
    bus.ch_write[c]              = wr;
    bus.ch_address[c*AW +: AW]   = a;
    bus.ch_data_in[c*32 +: 32]   = d;
    bus.ch_dqm[c*4 +: 4]         = m;
    bus.ch_req[c]                = 1'b1;
  endtask

  task automatic wait_ack(input int c, input int budget, output logic got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (bus.ch_ack[c]) got = 1'b1;
    end
  endtask

  task automatic wait_any(input int budget, output int who);
    who = -1;
    for (int i = 0; i < budget && who < 0; i++) begin
      step();
      if (bus.ch_ack[0]) who = 0;
      else if (bus.ch_ack[1]) who = 1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_en"}, cmd_en, 0);
    check({tag, "_ch_ack"}, bus.ch_ack, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_data_out"}, bus.ch_data_out, 0);
    check({tag, "_cmd"}, cmd, 0);
    check({tag, "_addr"}, addr, 0);
    check({tag, "_wdata"}, wdata, 0);
    check({tag, "_dqm"}, dqm, 0);
    check({tag, "_len"}, dlen, 0);
  endtask

  initial begin
    logic got;
    int   who, acks_seen;
    int   exp_seq [4];

    rst = 1'b1; init_done = 1'b0;
    bus.ch_req = '0; bus.ch_write = '0; bus.ch_address = '0;
    bus.ch_data_in = '0; bus.ch_dqm = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    ack_cd = 0; rd_cd = 0; n_cmds = 0; n_refresh = 0; last_ref = -1;
    min_gap = 1000000; max_gap = 0; violations = 0;
    outstanding = 1'b0; rd_acked = 1'b0; cmd_ack = 1'b0; rdata = 32'h0BAD0BAD;

    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;

    // Controller not initialised: request must wait.
    set_req(0, 1'b1, 21'h00010, 32'hDEADBEEF, 4'h0);
    repeat (100) step();
    check("init_low_cmds", n_cmds, 0);
    check("init_low_busy", busy, 0);
    init_done = 1'b1;
    step();
    check("grant_cmd_en", cmd_en, 1);
    bus.ch_data_in[31:0] = 32'h12345678;
    bus.ch_address[AW-1:0] = 21'h0003F;
    wait_ack(0, 20, got);
    bus.ch_req[0] = 1'b0;
    check("wr_ack0", got, 1);
    check("wr_cmd", last_cmd, C_WR);
    check("wr_addr", last_addr, 21'h00010);
    check("wr_data", last_data, 32'hDEADBEEF);
    check("wr_len", last_len, 0);
    check("latched_data", wdata, 32'hDEADBEEF);
    check("latched_addr", addr, 21'h00010);

    // Ch1 reads back what ch0 wrote.
    set_req(1, 1'b0, 21'h00010, 32'h0, 4'h0);
    wait_ack(1, 40, got);
    bus.ch_req[1] = 1'b0;
    check("rd_ack1", got, 1);
    check("rd_data", bus.ch_data_out, 32'hDEADBEEF);
    check("rd_no_ack0", bus.ch_ack[0], 0);
    check("rd_cmd", last_cmd, C_RD);

    // Byte masks: bytes 0 and 2 masked keep the old 0x11223344 bytes.
    step();
    set_req(0, 1'b1, 21'h00011, 32'h11223344, 4'h0);
    wait_ack(0, 40, got);
    bus.ch_req[0] = 1'b0;
    check("dqm_wr1_ack", got, 1);
    step();
    set_req(0, 1'b1, 21'h00011, 32'hAABBCCDD, 4'b0101);
    wait_ack(0, 40, got);
    bus.ch_req[0] = 1'b0;
    check("dqm_wr2_ack", got, 1);
    step();
    set_req(0, 1'b0, 21'h00011, 32'h0, 4'h0);
    wait_ack(0, 40, got);
    bus.ch_req[0] = 1'b0;
    check("dqm_rd_ack", got, 1);
    check("dqm_rd_data", bus.ch_data_out, 32'hAA22CC44);
    step();

    // Both channels request continuously; pointer currently points at ch1.
`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{1, 0, 1, 0};
`endif
    set_req(0, 1'b1, 21'h00020, 32'h55AA55AA, 4'h0);
    set_req(1, 1'b0, 21'h00010, 32'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      wait_any(40, who);
      check($sformatf("alt_grant_%0d", i), who, exp_seq[i]);
    end
    acks_seen = 0;
    for (int i = 0; i < 16; i++) begin
      wait_any(40, who);
      if (who >= 0) acks_seen++;
    end
    bus.ch_req = '0;
    check("cont_acks", acks_seen, 16);
    check("refresh_seen", (n_refresh >= 3), 1);
    check("refresh_min_gap", (min_gap >= RI), 1);
    check("refresh_max_gap", (max_gap <= MAX_GAP), 1);

    // Reset while waiting for read data.
    repeat (30) step();
    rd_acked = 1'b0;
    set_req(1, 1'b0, 21'h00010, 32'h0, 4'h0);
    for (int i = 0; i < 60 && !rd_acked; i++) step();
    check("pre_rst_rd_acked", rd_acked, 1);
    step();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    bus.ch_req[1] = 1'b0;
    #1;
    check_all_zero("midrst");
    acks_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 2) rst = 1'b0;
      if (|bus.ch_ack) acks_seen++;
    end
    check("midrst_no_ack", acks_seen, 0);
    set_req(1, 1'b0, 21'h00010, 32'h0, 4'h0);
    wait_ack(1, 40, got);
    bus.ch_req[1] = 1'b0;
    check("post_rst_ack", got, 1);
    check("post_rst_data", bus.ch_data_out, 32'hDEADBEEF);
    repeat (5) step();
    check("protocol_violations", violations, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
